bus_cycle_arbiter: RTL and testbench
====================================

# bus_cycle_arbiter

Two-port bus master that shares the 8088-style multiplexed memory/IO bus (ALE, IOM, RD, WR, 20-bit Address, 8-bit bidirectional Data) between two requesters. It arbitrates round-robin, latches the winning request, and sequences a four-clock T1–T4 bus cycle that the memory slaves on the bus decode. Read data and a one-cycle completion pulse are returned to the granted requester. It sits between the test masters / DMA-side logic and the memory_2-class slave devices.

## Interface
- ADDR_W, 20, bus address width
- DATA_W, 8, bus data width
- CLK  in  1  bus clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- req0 / req1  in  1  request level, held high until the matching done pulse
- we0 / we1  in  1  1 = write cycle, 0 = read cycle
- iom0 / iom1  in  1  driven onto IOM (0 = memory, 1 = IO)
- addr0 / addr1  in  ADDR_W  cycle address
- wdata0 / wdata1  in  DATA_W  write data
- done0 / done1  out  1  one-cycle completion pulse to the granted requester
- rdata  out  DATA_W  read data, valid while done0/done1 is high
- busy  out  1  high from T1 through T4
- ALE  out  1  address latch enable, active-high
- IOM  out  1  memory/IO select
- RD  out  1  read strobe, active-low
- WR  out  1  write strobe, active-low
- Address  out  ADDR_W  bus address
- Data  inout  DATA_W  bus data; driven only during write T2–T3, else high-Z

## Operation
- FSM states: IDLE, T1, T2, T3, T4 (one-hot encoding).
- Arbitration point: IDLE, and T4 (for back-to-back cycles). If no req, IDLE. If one req, grant it. If both, grant the port not granted last (last_gnt pointer).
- On grant: latch we, iom, addr, wdata, port id into cycle registers; update last_gnt; next state T1. Requester fields need not stay stable after grant.
- T1: ALE=1, Address=latched addr, IOM=latched iom, RD=WR=1.
- T2: ALE=0; RD=0 if read, WR=0 if write; Data driven with latched wdata on writes.
- T3: strobe and write data held; read data sampled from Data on the edge leaving T3 into rdata.
- T4: RD=WR=1, Data released; done of the granted port high for this cycle; rdata holds sampled value (writes: rdata unchanged).
- T4 -> T1 if a request is pending at T4 (arbitration as above, excluding the port just completing only if its req dropped), else IDLE. A port whose req stays high after its done is treated as a new request.
- Address and IOM hold the latched values from T1 through T4; in IDLE they retain the last values.
- A req that drops before grant is ignored; a req that drops after grant does not abort the cycle.
- Slave decode (e.g. Address[19] for the upper-half RAM) is not checked; unclaimed reads return whatever Data floats to.

## Timing
- Reset values: state IDLE, ALE=0, RD=1, WR=1, IOM=0, Address=0, Data high-Z, done0=done1=0, rdata=0, busy=0, last_gnt=1 (port 0 wins the first tie).
- RESET mid-cycle: next edge forces IDLE and all reset values; the cycle is discarded, no done issued.
- Latency: req high in IDLE at edge N -> T1 during cycle N+1, T4/done during cycle N+4; read data valid with done.
- Back-to-back: continuous traffic yields one cycle per 4 clocks, no IDLE gap.
- All outputs registered; no combinational path from req*/addr*/wdata* to bus pins.
- Data drive and RD low never overlap; WR and RD never low together.

## Test plan
- Reset then single read: req0=1, we0=0, addr0=20'h80010, memory holds 8'hA5 -> ALE in T1, RD low T2–T3, done0 in cycle 4 after grant with rdata=8'hA5.
- Single write then read back: req1 write 8'h3C to 20'h80020, then read -> WR low T2–T3, Data=8'h3C, readback rdata=8'h3C, done1 each time.
- Simultaneous contention: req0 and req1 held high from reset -> grants 0,1,0,1 alternate, each cycle 4 clocks, no IDLE between.
- Single requester streaming: req0 held for 3 cycles, req1 low -> three consecutive grants to port 0, back-to-back.
- Reset mid-cycle: assert RESET during T2 of a write -> next edge IDLE, WR=1, Data high-Z, no done pulse.
- Request withdrawn: req1 pulsed low before arbitration while cycle 0 busy -> port 1 never granted, bus returns to IDLE after port 0's T4.

Source files
------------

// File: rtl/bus_cycle_arbiter_if.sv
// Bus-side signal bundle for bus_cycle_arbiter: two requester ports plus the
// 8088-style control/address pins. The bidirectional Data bus stays a plain
// inout on the arbiter so tristate resolution happens on a module port.
interface bus_cycle_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    // Requester port 0
    logic              req0;
    logic              we0;
    logic              iom0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              done0;

    // Requester port 1
    logic              req1;
    logic              we1;
    logic              iom1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              done1;

    // Shared return path and bus pins
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              ALE;
    logic              IOM;
    logic              RD;
    logic              WR;
    logic [ADDR_W-1:0] Address;

    // Arbiter view: requests in, completions and bus pins out
    modport master (
        input  req0, we0, iom0, addr0, wdata0,
        input  req1, we1, iom1, addr1, wdata1,
        output done0, done1, rdata, busy,
        output ALE, IOM, RD, WR, Address
    );

    // Requester/slave-side view
    modport slave (
        output req0, we0, iom0, addr0, wdata0,
        output req1, we1, iom1, addr1, wdata1,
        input  done0, done1, rdata, busy,
        input  ALE, IOM, RD, WR, Address
    );
endinterface

// File: rtl/bus_cycle_arbiter.sv
// Two-port round-robin bus master sequencing a four-clock T1..T4 cycle on an
// 8088-style multiplexed bus. The winning request is latched at grant, so the
// requester fields may change afterwards; all bus pins come from flops.
module bus_cycle_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    bus_cycle_arbiter_if.master bus,
    inout  wire  [DATA_W-1:0]   Data
);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        T1   = 5'b00010,
        T2   = 5'b00100,
        T3   = 5'b01000,
        T4   = 5'b10000
    } state_t;

    state_t            state_q;

    // Cycle registers latched at grant
    logic              we_q;
    logic              port_q;
    logic [DATA_W-1:0] wdata_q;
    logic              last_gnt_q;

    // Registered bus pins and requester-side outputs
    logic              ale_q;
    logic              iom_q;
    logic              rd_n_q;
    logic              wr_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic              drive_q;
    logic              done0_q;
    logic              done1_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;

    // Arbitration result and the winning requester's fields
    logic              grant_vld_d;
    logic              grant_port_d;
    logic              sel_we_d;
    logic              sel_iom_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    // Round-robin pick: a lone request wins, a tie goes to the port not granted last
    always_comb begin
        grant_vld_d  = bus.req0 | bus.req1;
        grant_port_d = (bus.req0 & bus.req1) ? ~last_gnt_q : bus.req1;
        sel_we_d     = grant_port_d ? bus.we1    : bus.we0;
        sel_iom_d    = grant_port_d ? bus.iom1   : bus.iom0;
        sel_addr_d   = grant_port_d ? bus.addr1  : bus.addr0;
        sel_wdata_d  = grant_port_d ? bus.wdata1 : bus.wdata0;
    end

    // Bus cycle sequencer with registered pin values for the state being entered
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            port_q     <= 1'b0;
            wdata_q    <= '0;
            last_gnt_q <= 1'b1;
            ale_q      <= 1'b0;
            iom_q      <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            addr_q     <= '0;
            drive_q    <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                // T4 doubles as an arbitration point so streams run without an IDLE gap
                IDLE, T4: begin
                    rd_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                    if (grant_vld_d) begin
                        state_q    <= T1;
                        busy_q     <= 1'b1;
                        ale_q      <= 1'b1;
                        addr_q     <= sel_addr_d;
                        iom_q      <= sel_iom_d;
                        we_q       <= sel_we_d;
                        wdata_q    <= sel_wdata_d;
                        port_q     <= grant_port_d;
                        last_gnt_q <= grant_port_d;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ale_q   <= 1'b0;
                    end
                end
                T1: begin
                    state_q <= T2;
                    ale_q   <= 1'b0;
                    rd_n_q  <= we_q;
                    wr_n_q  <= ~we_q;
                    drive_q <= we_q;
                end
                T2: begin
                    state_q <= T3;
                end
                T3: begin
                    state_q <= T4;
                    rd_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                    if (!we_q) begin
                        rdata_q <= Data;
                    end
                    done0_q <= (port_q == 1'b0);
                    done1_q <= (port_q == 1'b1);
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ale_q   <= 1'b0;
                    rd_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_q;
    assign bus.ALE     = ale_q;
    assign bus.IOM     = iom_q;
    assign bus.RD      = rd_n_q;
    assign bus.WR      = wr_n_q;
    assign bus.Address = addr_q;

    assign Data = drive_q ? wdata_q : 'z;

    // Strobe sanity: read and write never overlap, and Data is never driven while reading
    a_no_rd_wr: assert property (@(posedge CLK) disable iff (RESET) !(!rd_n_q && !wr_n_q));
    a_no_drive_rd: assert property (@(posedge CLK) disable iff (RESET) !(drive_q && !rd_n_q));

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Self-checking bench for bus_cycle_arbiter: directed scenarios followed by
// randomized traffic, checked every cycle against a transaction-level model.
module tb_bus_cycle_arbiter;
    localparam int AW = 20;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    wire  [DW-1:0] Data;

    bus_cycle_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    bus_cycle_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bif),
        .Data  (Data)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          we;
        logic          iom;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    // Requester stimulus
    txn_t    pq0[$];
    txn_t    pq1[$];
    logic    req_v [2];
    logic    xreq  [2];
    txn_t    fld_v [2];
    logic    gap_en;

    assign bif.req0   = req_v[0] | xreq[0];
    assign bif.we0    = fld_v[0].we;
    assign bif.iom0   = fld_v[0].iom;
    assign bif.addr0  = fld_v[0].addr;
    assign bif.wdata0 = fld_v[0].wdata;
    assign bif.req1   = req_v[1] | xreq[1];
    assign bif.we1    = fld_v[1].we;
    assign bif.iom1   = fld_v[1].iom;
    assign bif.addr1  = fld_v[1].addr;
    assign bif.wdata1 = fld_v[1].wdata;

    // Memory slave on the bus
    logic          slv_drv;
    logic [DW-1:0] slv_val;
    logic [DW-1:0] slv_mem [logic [AW-1:0]];
    assign Data = slv_drv ? slv_val : 'z;

    // Reference model state
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic          m_active;
    int            m_start;
    logic          m_port;
    txn_t          m_txn;
    logic          m_last;
    logic [AW-1:0] m_addr;
    logic          m_iom;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_exp_rd;

    // Observations
    int            nerr = 0;
    int            nchk = 0;
    int            cyc  = 0;
    int            done_cnt [2];
    logic          seen_done [2];
    logic          gnt_log[$];
    int            raise_cyc [2];
    int            last_done_cyc;
    logic [DW-1:0] last_done_rdata;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [DW-1:0] slv_rd(input logic [AW-1:0] a);
        if (slv_mem.exists(a)) return slv_mem[a];
        return dflt(a);
    endfunction

    function automatic txn_t mk(input logic we, input logic iom,
                                input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        txn_t t;
        t.we    = we;
        t.iom   = iom;
        t.addr  = addr;
        t.wdata = wd;
        return t;
    endfunction

    function automatic txn_t junk();
        logic [31:0] r;
        r = $urandom;
        return r[29:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive requesters and advance the model for the coming edge,
    // then check the DUT against the model at the following negedge.
    task automatic step(input logic rst);
        int   o;
        logic arb_next;
        logic r0, r1, pg;
        RESET    = rst;
        o        = cyc - m_start;
        arb_next = !m_active || (o == 3);

        for (int p = 0; p < 2; p++) begin
            int n;
            if (seen_done[p]) begin
                if (p == 0 && pq0.size() > 0) void'(pq0.pop_front());
                if (p == 1 && pq1.size() > 0) void'(pq1.pop_front());
            end
            seen_done[p] = 1'b0;
            n = (p == 0) ? pq0.size() : pq1.size();
            if (n > 0) begin
                if (!req_v[p] && (!gap_en || $urandom_range(0, 1) == 0)) begin
                    req_v[p]     = 1'b1;
                    raise_cyc[p] = cyc;
                end
                // Once granted, the requester's fields are free to wander
                if (req_v[p] && m_active && !arb_next && m_port == p[0])
                    fld_v[p] = junk();
                else
                    fld_v[p] = (p == 0) ? pq0[0] : pq1[0];
            end else begin
                req_v[p] = 1'b0;
                fld_v[p] = junk();
            end
        end

        if (rst) begin
            m_active = 1'b0;
            m_last   = 1'b1;
            m_addr   = '0;
            m_iom    = 1'b0;
            m_rdata  = '0;
        end else if (arb_next) begin
            r0 = req_v[0] | xreq[0];
            r1 = req_v[1] | xreq[1];
            if (r0 || r1) begin
                pg       = (r0 && r1) ? !m_last : r1;
                m_active = 1'b1;
                m_start  = cyc + 1;
                m_port   = pg;
                m_last   = pg;
                m_txn    = pg ? fld_v[1] : fld_v[0];
                m_addr   = m_txn.addr;
                m_iom    = m_txn.iom;
                if (m_txn.we) ref_mem[m_txn.addr] = m_txn.wdata;
                else          m_exp_rd = ref_rd(m_txn.addr);
            end else begin
                m_active = 1'b0;
            end
        end

        @(negedge CLK);
        cyc++;
        o = cyc - m_start;

        if (m_active) begin
            if (o == 3 && !m_txn.we) m_rdata = m_exp_rd;
            chk("busy",    32'(bif.busy),    32'd1);
            chk("ALE",     32'(bif.ALE),     32'(o == 0));
            chk("Address", 32'(bif.Address), 32'(m_txn.addr));
            chk("IOM",     32'(bif.IOM),     32'(m_txn.iom));
            chk("RD",      32'(bif.RD),      32'(!(!m_txn.we && (o == 1 || o == 2))));
            chk("WR",      32'(bif.WR),      32'(!(m_txn.we && (o == 1 || o == 2))));
            chk("done0",   32'(bif.done0),   32'(o == 3 && m_port == 1'b0));
            chk("done1",   32'(bif.done1),   32'(o == 3 && m_port == 1'b1));
            if (m_txn.we && (o == 1 || o == 2)) chk("Data_wr", 32'(Data), 32'(m_txn.wdata));
            if (!m_txn.we && o == 2)            chk("Data_rd", 32'(Data), 32'(m_exp_rd));
        end else begin
            chk("idle_busy",    32'(bif.busy),    32'd0);
            chk("idle_ALE",     32'(bif.ALE),     32'd0);
            chk("idle_RD",      32'(bif.RD),      32'd1);
            chk("idle_WR",      32'(bif.WR),      32'd1);
            chk("idle_done0",   32'(bif.done0),   32'd0);
            chk("idle_done1",   32'(bif.done1),   32'd0);
            chk("idle_Address", 32'(bif.Address), 32'(m_addr));
            chk("idle_IOM",     32'(bif.IOM),     32'(m_iom));
        end
        chk("rdata", 32'(bif.rdata), 32'(m_rdata));

        seen_done[0] = bif.done0;
        seen_done[1] = bif.done1;
        if (bif.done0) begin
            done_cnt[0]++;
            gnt_log.push_back(1'b0);
            last_done_cyc   = cyc;
            last_done_rdata = bif.rdata;
        end
        if (bif.done1) begin
            done_cnt[1]++;
            gnt_log.push_back(1'b1);
            last_done_cyc   = cyc;
            last_done_rdata = bif.rdata;
        end

        if (!bif.WR) slv_mem[bif.Address] = Data;
        if (!bif.RD) begin
            slv_drv = 1'b1;
            slv_val = slv_rd(bif.Address);
        end else begin
            slv_drv = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pq0.size() > 0 || pq1.size() > 0 || m_active || req_v[0] || req_v[1]) && n < budget) begin
            step(1'b0);
            n++;
        end
        chk("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int d0, d1, npush, got;
        logic [31:0] r;

        RESET     = 1'b1;
        gap_en    = 1'b0;
        xreq[0]   = 1'b0;
        xreq[1]   = 1'b0;
        req_v[0]  = 1'b0;
        req_v[1]  = 1'b0;
        slv_drv   = 1'b0;
        slv_val   = '0;
        m_active  = 1'b0;
        m_start   = 0;
        m_last    = 1'b1;
        m_rdata   = '0;
        m_addr    = '0;
        m_iom     = 1'b0;
        seen_done[0] = 1'b0;
        seen_done[1] = 1'b0;
        done_cnt[0]  = 0;
        done_cnt[1]  = 0;
        slv_mem[20'h80010] = 8'hA5;
        ref_mem[20'h80010] = 8'hA5;

        // Reset state
        step(1'b1);
        step(1'b1);
        chk("rst_busy",    32'(bif.busy),    32'd0);
        chk("rst_ALE",     32'(bif.ALE),     32'd0);
        chk("rst_RD",      32'(bif.RD),      32'd1);
        chk("rst_WR",      32'(bif.WR),      32'd1);
        chk("rst_IOM",     32'(bif.IOM),     32'd0);
        chk("rst_Address", 32'(bif.Address), 32'd0);
        chk("rst_rdata",   32'(bif.rdata),   32'd0);
        chk("rst_done",    32'({bif.done1, bif.done0}), 32'd0);
        step(1'b0);

        // Single read from port 0
        pq0.push_back(mk(1'b0, 1'b0, 20'h80010, 8'h00));
        drain(20);
        chk("rd_latency", 32'(last_done_cyc - raise_cyc[0]), 32'd4);
        chk("rd_rdata",   32'(last_done_rdata), 32'hA5);
        chk("rd_done0",   32'(done_cnt[0]), 32'd1);

        // Write then read back on port 1
        pq1.push_back(mk(1'b1, 1'b0, 20'h80020, 8'h3C));
        pq1.push_back(mk(1'b0, 1'b0, 20'h80020, 8'h00));
        drain(30);
        chk("wr_slave_mem", 32'(slv_mem[20'h80020]), 32'h3C);
        chk("rb_rdata",     32'(last_done_rdata), 32'h3C);
        chk("rb_done1",     32'(done_cnt[1]), 32'd2);

        // Contention straight out of reset: 0,1,0,1,0,1 with no gaps
        step(1'b1);
        gnt_log.delete();
        for (int i = 0; i < 3; i++) begin
            pq0.push_back(mk(1'b0, 1'b0, 20'h80000 + 20'(i), 8'h00));
            pq1.push_back(mk(1'b1, 1'b1, 20'h80040 + 20'(i), 8'(8'h10 + i)));
        end
        drain(60);
        chk("cont_count", 32'(gnt_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            chk("cont_order", 32'(gnt_log[i]), 32'(i % 2));
        chk("cont_span", 32'(last_done_cyc - raise_cyc[0]), 32'd24);

        // Single requester streaming three cycles back to back
        gnt_log.delete();
        pq0.push_back(mk(1'b1, 1'b0, 20'h80050, 8'h91));
        pq0.push_back(mk(1'b0, 1'b0, 20'h80050, 8'h00));
        pq0.push_back(mk(1'b1, 1'b1, 20'h00007, 8'h6E));
        drain(40);
        chk("stream_count", 32'(gnt_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < gnt_log.size(); i++)
            chk("stream_port", 32'(gnt_log[i]), 32'd0);
        chk("stream_span", 32'(last_done_cyc - raise_cyc[0]), 32'd12);

        // Reset during T2 of a write
        d0 = done_cnt[0];
        pq0.push_back(mk(1'b1, 1'b0, 20'h80030, 8'h77));
        for (int i = 0; i < 10 && !(m_active && (cyc - m_start) == 1); i++) step(1'b0);
        chk("mid_reached_T2", 32'(m_active && (cyc - m_start) == 1), 32'd1);
        chk("mid_WR_low", 32'(bif.WR), 32'd0);
        pq0.delete();
        step(1'b1);
        chk("mid_WR",      32'(bif.WR),      32'd1);
        chk("mid_busy",    32'(bif.busy),    32'd0);
        chk("mid_Address", 32'(bif.Address), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("mid_no_done", 32'(done_cnt[0]), 32'(d0));

        // Port 1 request withdrawn before it reaches an arbitration point
        d1 = done_cnt[1];
        pq0.push_back(mk(1'b0, 1'b0, 20'h80010, 8'h00));
        for (int i = 0; i < 10 && !m_active; i++) step(1'b0);
        chk("wd_started", 32'(m_active), 32'd1);
        xreq[1] = 1'b1;
        step(1'b0);
        step(1'b0);
        xreq[1] = 1'b0;
        drain(20);
        step(1'b0);
        chk("wd_no_done1", 32'(done_cnt[1]), 32'(d1));
        chk("wd_idle",     32'(bif.busy),    32'd0);

        // Randomized traffic on both ports with random request gaps
        gap_en = 1'b1;
        d0     = done_cnt[0];
        d1     = done_cnt[1];
        npush  = 0;
        for (int i = 0; i < 160; i++) begin
            r = $urandom;
            if (r[0]) pq1.push_back(mk(r[1], r[2], 20'h80000 + 20'(r[7:3]), r[15:8]));
            else      pq0.push_back(mk(r[1], r[2], 20'h80000 + 20'(r[7:3]), r[15:8]));
            npush++;
        end
        drain(5000);
        got = (done_cnt[0] - d0) + (done_cnt[1] - d1);
        chk("rand_completions", 32'(got), 32'(npush));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
